// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/pc_register.sv
// Program counter state and next-pc selection (redirect > stall > sequential).
// FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky trap and freezes the pc.
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            trap_o,
`endif
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    pc_d   = pc_q;
    trap_d = trap_q;
    if (trap_q) begin
      pc_d = pc_q;
    end else if (branch_taken_i) begin
      if (branch_target_i[1:0] != 2'b00) trap_d = 1'b1;
      else                               pc_d   = branch_target_i;
    end else if (!stall_i) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) trap_q <= 1'b0;
    else         trap_q <= trap_d;
  end

  assign trap_o = trap_q;
`else
  // Low target bits are dropped so the pc can never hold a misaligned value.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i)  pc_d = branch_target_i & ~XLEN'(3);
    else if (!stall_i)   pc_d = pc_q + XLEN'(INSTR_BYTES);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I IF stage: drives imem with the pc, captures the returned word into IF/ID.
// FETCH_MISALIGN_TRAP_EN adds the sticky misaligned_trap output.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd_instr,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            misaligned_trap,
`endif
  output logic [31:0]     fetch_count
);

  localparam if_id_t IF_ID_EMPTY = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc;
  logic            flush;
  if_id_t          if_id_q, if_id_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  pc_register #(.RESET_PC(RESET_PC), .XLEN(XLEN)) u_pc (
    .clk_i           (clk),
    .reset_i         (reset),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
`ifdef FETCH_MISALIGN_TRAP_EN
    .trap_o          (misaligned_trap),
`endif
    .pc_o            (pc)
  );

  // A taken redirect discards the wrong-path word even while stalled.
`ifdef FETCH_MISALIGN_TRAP_EN
  assign flush = branch_taken | misaligned_trap;
`else
  assign flush = branch_taken;
`endif

  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      if_id_d = IF_ID_EMPTY;
    end else if (!stall) begin
      if_id_d       = '{instr: imem_rd_instr, pc: pc, pc_plus4: pc + XLEN'(INSTR_BYTES), valid: 1'b1};
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q       <= IF_ID_EMPTY;
      fetch_count_q <= '0;
    end else begin
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr      = pc;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + scoreboard bench for instruction_fetch with a zero-latency instruction memory.
module tb_instruction_fetch;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rd_instr;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        if_id_valid;
  logic        trap_obs;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_rd_instr = mem[imem_addr[7:2]];

  instruction_fetch #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rd_instr  (imem_rd_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned_trap(trap_obs),
`endif
    .fetch_count    (fetch_count)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign trap_obs = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc, instr, ipc, ip4, cnt;
    logic        valid, trap;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_cnt;
  logic        m_valid, m_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_flush();
    m_instr = 32'h0000_0013; m_ipc = '0; m_ip4 = '0; m_valid = 1'b0;
  endtask

  task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
    exp_t e;
    reset = rst; stall = st; branch_taken = br; branch_target = tgt;
    if (rst) begin
      m_pc = '0; m_cnt = '0; m_trap = 1'b0; m_flush();
    end else if (m_trap) begin
      m_flush();
    end else if (br) begin
      if (TRAP_EN && tgt[1:0] != 2'b00) m_trap = 1'b1;
      else                              m_pc = {tgt[31:2], 2'b00};
      m_flush();
    end else if (!st) begin
      m_instr = mem[m_pc[7:2]]; m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    e = '{pc: m_pc, instr: m_instr, ipc: m_ipc, ip4: m_ip4, cnt: m_cnt, valid: m_valid, trap: m_trap};
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("sb_pc",    imem_addr,      e.pc);
      chk("sb_instr", if_id_instr,    e.instr);
      chk("sb_ifpc",  if_id_pc,       e.ipc);
      chk("sb_ifp4",  if_id_pc_plus4, e.ip4);
      chk("sb_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      chk("sb_cnt",   fetch_count,    e.cnt);
      chk("sb_trap",  {31'b0, trap_obs}, {31'b0, e.trap});
    end
  endtask

  initial begin
    logic [31:0] held_pc;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    #2;

    // Reset held two cycles
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h44);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h13);
    chk("rst_cnt",   fetch_count, 32'h0);

    // Sequential fetch
    repeat (4) step(0, 0, 0, 0);
    chk("seq_addr",  imem_addr, 32'h10);
    chk("seq_ifpc",  if_id_pc, 32'hC);
    chk("seq_ifp4",  if_id_pc_plus4, 32'h10);
    chk("seq_instr", if_id_instr, mem[3]);
    chk("seq_cnt",   fetch_count, 32'd4);

    // Stall at pc=0x8
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("stl_addr",  imem_addr, 32'h8);
    chk("stl_ifpc",  if_id_pc, 32'h4);
    chk("stl_instr", if_id_instr, mem[1]);
    chk("stl_cnt",   fetch_count, 32'd2);
    step(0, 0, 0, 0);
    chk("stl_rel_ifpc", if_id_pc, 32'h8);

    // Branch wins over stall
    step(0, 1, 1, 32'h40);
    chk("brs_addr",  imem_addr, 32'h40);
    chk("brs_valid", {31'b0, if_id_valid}, 32'h0);
    chk("brs_instr", if_id_instr, 32'h13);
    chk("brs_cnt",   fetch_count, 32'd3);
    step(0, 0, 0, 0);
    chk("brs_ifpc",  if_id_pc, 32'h40);
    chk("brs_vld2",  {31'b0, if_id_valid}, 32'h1);
    chk("brs_instr2", if_id_instr, mem[16]);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_ifp4", if_id_pc_plus4, 32'h0);

    // Mixed traffic against the scoreboard
    for (int i = 0; i < 24; i++) begin
      logic br;
      br = ($urandom_range(0, 4) == 0);
      step(0, $urandom_range(0, 2) == 0, br, {24'h0, 2'b00, 6'($urandom_range(0, 63))} << 2);
    end

    // Misaligned target
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    held_pc = imem_addr;
    step(0, 0, 1, 32'h42);
    if (TRAP_EN) begin
      chk("mis_trap",  {31'b0, trap_obs}, 32'h1);
      chk("mis_hold",  imem_addr, held_pc);
      chk("mis_valid", {31'b0, if_id_valid}, 32'h0);
      step(0, 0, 0, 0);
      step(0, 1, 1, 32'h80);
      step(0, 0, 0, 0);
      chk("mis_sticky", {31'b0, trap_obs}, 32'h1);
      chk("mis_hold2",  imem_addr, held_pc);
      chk("mis_vld2",   {31'b0, if_id_valid}, 32'h0);
      step(1, 0, 0, 0);
      chk("mis_rst",    {31'b0, trap_obs}, 32'h0);
    end else begin
      chk("mis_align", imem_addr, 32'h40);
      step(0, 0, 0, 0);
      chk("mis_ifpc",  if_id_pc, 32'h40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
